// File: rtl/cc_mim_microsequencer_if.sv
// Control-store / datapath handshake bundle for the microsequencer.
// Signals:
//   microword_InBUS  microword returned by the control store
//   ir_InBUS         instruction register
//   flags_InBUS      {n,z,v,c} from the PSR
//   memReady_In      memory completed the current RD/WR
//   haltReq_In       request to freeze sequencing
//   address_OutBUS   registered microaddress to the control store
//   stall_Out        datapath must not commit this cycle
//   halted_Out       sequencer is in HALT
//   memTimeout_Out   sticky memory-timeout error
// master = sequencer side, slave = control store / datapath side.
interface cc_mim_microsequencer_if #(
  parameter int unsigned DATAWIDTH_ADDR      = 11,
  parameter int unsigned DATAWIDTH_MICROWORD = 41,
  parameter int unsigned DATAWIDTH_IR        = 32
);
  logic [DATAWIDTH_MICROWORD-1:0] CC_MIM_MICROSEQ_microword_InBUS;
  logic [DATAWIDTH_IR-1:0]        CC_MIM_MICROSEQ_ir_InBUS;
  logic [3:0]                     CC_MIM_MICROSEQ_flags_InBUS;
  logic                           CC_MIM_MICROSEQ_memReady_In;
  logic                           CC_MIM_MICROSEQ_haltReq_In;
  logic [DATAWIDTH_ADDR-1:0]      CC_MIM_MICROSEQ_address_OutBUS;
  logic                           CC_MIM_MICROSEQ_stall_Out;
  logic                           CC_MIM_MICROSEQ_halted_Out;
  logic                           CC_MIM_MICROSEQ_memTimeout_Out;

  modport master (
    input  CC_MIM_MICROSEQ_microword_InBUS,
    input  CC_MIM_MICROSEQ_ir_InBUS,
    input  CC_MIM_MICROSEQ_flags_InBUS,
    input  CC_MIM_MICROSEQ_memReady_In,
    input  CC_MIM_MICROSEQ_haltReq_In,
    output CC_MIM_MICROSEQ_address_OutBUS,
    output CC_MIM_MICROSEQ_stall_Out,
    output CC_MIM_MICROSEQ_halted_Out,
    output CC_MIM_MICROSEQ_memTimeout_Out
  );

  modport slave (
    output CC_MIM_MICROSEQ_microword_InBUS,
    output CC_MIM_MICROSEQ_ir_InBUS,
    output CC_MIM_MICROSEQ_flags_InBUS,
    output CC_MIM_MICROSEQ_memReady_In,
    output CC_MIM_MICROSEQ_haltReq_In,
    input  CC_MIM_MICROSEQ_address_OutBUS,
    input  CC_MIM_MICROSEQ_stall_Out,
    input  CC_MIM_MICROSEQ_halted_Out,
    input  CC_MIM_MICROSEQ_memTimeout_Out
  );
endinterface

// File: rtl/cc_mim_microsequencer.sv
// Microprogram counter and branch unit. Holds the current microaddress,
// decodes COND/JUMP of the returned microword together with the PSR flags
// and the IR to pick the next microaddress, stalls on memory handshakes,
// supports halting and raises a sticky error on memory timeout.
// Ports:
//   CC_MIM_MICROSEQ_CLOCK_50     rising-edge clock
//   CC_MIM_MICROSEQ_RESET_InLow  asynchronous active-low reset
//   bus                          handshake bundle (master modport)
module cc_mim_microsequencer #(
  parameter int unsigned DATAWIDTH_ADDR      = 11,
  parameter int unsigned DATAWIDTH_MICROWORD = 41,
  parameter int unsigned DATAWIDTH_IR        = 32,
  parameter int unsigned MEM_TIMEOUT         = 255
) (
  input  logic                    CC_MIM_MICROSEQ_CLOCK_50,
  input  logic                    CC_MIM_MICROSEQ_RESET_InLow,
  cc_mim_microsequencer_if.master bus
);

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic [5:0]  a;
    logic        amux;
    logic [5:0]  b;
    logic        bmux;
    logic [5:0]  c;
    logic        cmux;
    logic        rd;
    logic        wr;
    logic [3:0]  alu;
    logic [2:0]  cond;
    logic [10:0] jump;
  } microword_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [DATAWIDTH_ADDR-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;
  logic                      stall_q, stall_d;
  logic                      halted_q, halted_d;

  microword_t                mw_c;
  logic [DATAWIDTH_IR-1:0]   ir_c;
  logic [3:0]                flags_c;
  logic                      mem_req_c;
  logic                      ready_c;
  logic                      halt_req_c;
  logic [DATAWIDTH_ADDR-1:0] inc_c;
  logic [DATAWIDTH_ADDR-1:0] next_addr_c;
  logic [CNT_W-1:0]          cnt_inc_c;
  logic                      unused_bits_c;

  assign mw_c       = microword_t'(bus.CC_MIM_MICROSEQ_microword_InBUS);
  assign ir_c       = bus.CC_MIM_MICROSEQ_ir_InBUS;
  assign flags_c    = bus.CC_MIM_MICROSEQ_flags_InBUS;
  assign ready_c    = bus.CC_MIM_MICROSEQ_memReady_In;
  assign halt_req_c = bus.CC_MIM_MICROSEQ_haltReq_In;
  assign mem_req_c  = mw_c.rd | mw_c.wr;
  assign inc_c      = addr_q + DATAWIDTH_ADDR'(1);
  assign cnt_inc_c  = cnt_q + CNT_W'(1);

  // Datapath-only microword fields and IR bits outside op/op3/i.
  assign unused_bits_c = ^{mw_c.a, mw_c.amux, mw_c.b, mw_c.bmux, mw_c.c,
                           mw_c.cmux, mw_c.alu, ir_c[29:25], ir_c[18:14],
                           ir_c[12:0]};

  // Next-address mux; flags are {n,z,v,c}.
  always_comb begin
    next_addr_c = inc_c;
    case (mw_c.cond)
      3'b000:  next_addr_c = inc_c;
      3'b001:  next_addr_c = flags_c[3] ? mw_c.jump : inc_c;
      3'b010:  next_addr_c = flags_c[2] ? mw_c.jump : inc_c;
      3'b011:  next_addr_c = flags_c[1] ? mw_c.jump : inc_c;
      3'b100:  next_addr_c = flags_c[0] ? mw_c.jump : inc_c;
      3'b101:  next_addr_c = ir_c[13] ? mw_c.jump : inc_c;
      3'b110:  next_addr_c = {1'b1, ir_c[31:30], ir_c[24:19], 2'b00};
      default: next_addr_c = mw_c.jump;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CC_MIM_MICROSEQ_CLOCK_50 or negedge CC_MIM_MICROSEQ_RESET_InLow) begin
    if (!CC_MIM_MICROSEQ_RESET_InLow) begin
      state_q   <= ST_RUN;
      addr_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      stall_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      halted_q  <= halted_d;
    end
  end

  // Next state; a pending memory access takes priority over halt, and
  // memReady takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req_c && !ready_c) begin
          state_d = ST_MEMWAIT;
          cnt_d   = '0;
        end else begin
          addr_d = next_addr_c;
          if (halt_req_c) state_d = ST_HALT;
        end
      end
      ST_MEMWAIT: begin
        if (ready_c) begin
          addr_d  = next_addr_c;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_inc_c == CNT_W'(MEM_TIMEOUT)) begin
          timeout_d = 1'b1;
          addr_d    = '0;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end
      ST_HALT: begin
        if (!halt_req_c) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Registered status outputs follow the state being entered.
  always_comb begin
    stall_d  = 1'b0;
    halted_d = 1'b0;
    if (state_d != ST_RUN)  stall_d  = 1'b1;
    if (state_d == ST_HALT) halted_d = 1'b1;
  end

  assign bus.CC_MIM_MICROSEQ_address_OutBUS = addr_q;
  assign bus.CC_MIM_MICROSEQ_stall_Out      = stall_q;
  assign bus.CC_MIM_MICROSEQ_halted_Out     = halted_q;
  assign bus.CC_MIM_MICROSEQ_memTimeout_Out = timeout_q;

endmodule

// File: tb/tb_cc_mim_microsequencer.sv
// Bench for cc_mim_microsequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_cc_mim_microsequencer;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;

  cc_mim_microsequencer_if bus_if ();

  cc_mim_microsequencer #(.MEM_TIMEOUT(TO)) dut (
    .CC_MIM_MICROSEQ_CLOCK_50   (clk),
    .CC_MIM_MICROSEQ_RESET_InLow(rst_n),
    .bus                        (bus_if.master)
  );

  always #5 clk = ~clk;

  wire [10:0] dut_addr  = bus_if.CC_MIM_MICROSEQ_address_OutBUS;
  wire        dut_stall = bus_if.CC_MIM_MICROSEQ_stall_Out;
  wire        dut_halt  = bus_if.CC_MIM_MICROSEQ_halted_Out;
  wire        dut_to    = bus_if.CC_MIM_MICROSEQ_memTimeout_Out;

  int total = 0;
  int bad   = 0;

  // Model: current address, waiting on memory, halted, sticky error.
  int m_addr   = 0;
  bit m_wait   = 0;
  bit m_halt   = 0;
  bit m_to     = 0;
  int m_waited = 0;

  function automatic int model_next(input logic [40:0] w, input logic [31:0] ir,
                                    input logic [3:0] fl, input int a);
    int cond;
    int jump;
    int inc;
    cond = int'(w[13:11]);
    jump = int'(w[10:0]);
    inc  = (a + 1) % 2048;
    if (cond == 0) return inc;
    if (cond >= 1 && cond <= 4) return fl[4 - cond] ? jump : inc;
    if (cond == 5) return ir[13] ? jump : inc;
    if (cond == 6) return 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
    return jump;
  endfunction

  function automatic logic [40:0] mw(input bit rd, input bit wr,
                                     input int cond, input int jump);
    logic [40:0] w;
    w        = '0;
    w[19]    = rd;
    w[18]    = wr;
    w[13:11] = 3'(cond);
    w[10:0]  = 11'(jump);
    return w;
  endfunction

  function automatic logic [31:0] ir_of(input int op, input int op3, input bit i13);
    logic [31:0] r;
    r        = $urandom;
    r[31:30] = 2'(op);
    r[24:19] = 6'(op3);
    r[13]    = i13;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr   = 0;
    m_wait   = 0;
    m_halt   = 0;
    m_to     = 0;
    m_waited = 0;
  endtask

  // One clock: drive inputs, advance the model across the edge, return at negedge.
  task automatic cyc(input logic [40:0] w, input logic [31:0] ir, input logic [3:0] fl,
                     input bit rdy, input bit hlt);
    int na;
    bit nw, nh, nt;
    int nwt;
    bus_if.CC_MIM_MICROSEQ_microword_InBUS = w;
    bus_if.CC_MIM_MICROSEQ_ir_InBUS        = ir;
    bus_if.CC_MIM_MICROSEQ_flags_InBUS     = fl;
    bus_if.CC_MIM_MICROSEQ_memReady_In     = rdy;
    bus_if.CC_MIM_MICROSEQ_haltReq_In      = hlt;
    na = m_addr; nw = m_wait; nh = m_halt; nt = m_to; nwt = m_waited;
    if (m_halt) begin
      if (!hlt) nh = 0;
    end else if (m_wait) begin
      nwt = m_waited + 1;
      if (rdy) begin
        na = model_next(w, ir, fl, m_addr); nw = 0;
      end else if (nwt == int'(TO)) begin
        nt = 1; na = 0; nw = 0;
      end
    end else if ((w[19] || w[18]) && !rdy) begin
      nw = 1; nwt = 0;
    end else begin
      na = model_next(w, ir, fl, m_addr);
      nh = hlt;
    end
    @(posedge clk);
    m_addr = na; m_wait = nw; m_halt = nh; m_to = nt; m_waited = nwt;
    @(negedge clk);
  endtask

  // Async reset asserted between edges; released on a later negedge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    total++;
    if (dut_addr !== 11'(m_addr)) begin
      bad++;
      $display("FAIL cmp_addr: got %0d expected %0d at %0t", dut_addr, m_addr, $time);
    end
    total++;
    if (dut_stall !== (m_wait || m_halt)) begin
      bad++;
      $display("FAIL cmp_stall: got %0b expected %0b at %0t", dut_stall, m_wait || m_halt, $time);
    end
    total++;
    if (dut_halt !== m_halt) begin
      bad++;
      $display("FAIL cmp_halted: got %0b expected %0b at %0t", dut_halt, m_halt, $time);
    end
    total++;
    if (dut_to !== m_to) begin
      bad++;
      $display("FAIL cmp_timeout: got %0b expected %0b at %0t", dut_to, m_to, $time);
    end
  end

  initial begin
    logic [40:0] w;
    logic [31:0] ir;
    int slow;
    int hl;
    bit rdy;
    bit hlt;
    rst_n = 1'b1;
    bus_if.CC_MIM_MICROSEQ_microword_InBUS = '0;
    bus_if.CC_MIM_MICROSEQ_ir_InBUS        = '0;
    bus_if.CC_MIM_MICROSEQ_flags_InBUS     = '0;
    bus_if.CC_MIM_MICROSEQ_memReady_In     = 1'b0;
    bus_if.CC_MIM_MICROSEQ_haltReq_In      = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_addr", int'(dut_addr), 0);
    chk("reset_stall", int'(dut_stall), 0);
    chk("reset_halted", int'(dut_halt), 0);
    chk("reset_timeout", int'(dut_to), 0);
    rst_n = 1'b1;

    // Sequential fetch and wrap.
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("seq1", int'(dut_addr), 1);
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("seq2", int'(dut_addr), 2);
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("seq3", int'(dut_addr), 3);
    cyc(mw(0, 0, 7, 2047), 0, 0, 1, 0); chk("jump2047", int'(dut_addr), 2047);
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("wrap", int'(dut_addr), 0);

    // DECODE and IR[13] branch.
    cyc(mw(0, 0, 6, 0), ir_of(2, 6'b010000, 0), 0, 1, 0); chk("decode_addcc", int'(dut_addr), 1600);
    cyc(mw(0, 0, 5, 1602), ir_of(2, 0, 1), 0, 1, 0); chk("ir13_taken", int'(dut_addr), 1602);
    cyc(mw(0, 0, 7, 1600), 0, 0, 1, 0); chk("back1600", int'(dut_addr), 1600);
    cyc(mw(0, 0, 5, 1602), ir_of(2, 0, 0), 0, 1, 0); chk("ir13_not", int'(dut_addr), 1601);
    cyc(mw(0, 0, 6, 0), ir_of(3, 0, 0), 0, 1, 0); chk("decode_ld", int'(dut_addr), 1792);

    // Zero-flag branch.
    cyc(mw(0, 0, 2, 12), 0, 4'b0100, 1, 0); chk("z_taken", int'(dut_addr), 12);
    cyc(mw(0, 0, 2, 12), 0, 4'b1011, 1, 0); chk("z_not", int'(dut_addr), 13);

    // Memory wait: ready low three cycles, then high.
    cyc(mw(1, 0, 0, 0), 0, 0, 0, 0); chk("mw_addr1", int'(dut_addr), 13); chk("mw_stall1", int'(dut_stall), 1);
    cyc(mw(1, 0, 0, 0), 0, 0, 0, 0); chk("mw_addr2", int'(dut_addr), 13); chk("mw_stall2", int'(dut_stall), 1);
    cyc(mw(1, 0, 0, 0), 0, 0, 0, 0); chk("mw_addr3", int'(dut_addr), 13); chk("mw_stall3", int'(dut_stall), 1);
    cyc(mw(1, 0, 0, 0), 0, 0, 1, 0); chk("mw_addr4", int'(dut_addr), 14); chk("mw_stall4", int'(dut_stall), 0);

    // Timeout after four wait cycles.
    cyc(mw(0, 1, 0, 0), 0, 0, 0, 0);
    cyc(mw(0, 1, 0, 0), 0, 0, 0, 0);
    cyc(mw(0, 1, 0, 0), 0, 0, 0, 0);
    cyc(mw(0, 1, 0, 0), 0, 0, 0, 0); chk("to_not_yet", int'(dut_to), 0); chk("to_hold", int'(dut_addr), 14);
    cyc(mw(0, 1, 0, 0), 0, 0, 0, 0); chk("to_set", int'(dut_to), 1); chk("to_addr", int'(dut_addr), 0);
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("to_sticky", int'(dut_to), 1); chk("to_next", int'(dut_addr), 1);

    // Halt and resume.
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 1); chk("halt_addr", int'(dut_addr), 2); chk("halt_flag", int'(dut_halt), 1);
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 1); chk("halt_frozen", int'(dut_addr), 2);
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("unhalt_flag", int'(dut_halt), 0); chk("unhalt_addr", int'(dut_addr), 2);
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("resume", int'(dut_addr), 3);

    // Halt request during a pending read: memory wait completes first.
    cyc(mw(1, 0, 0, 0), 0, 0, 0, 1); chk("hm_stall", int'(dut_stall), 1);
    cyc(mw(1, 0, 0, 0), 0, 0, 1, 1); chk("hm_addr", int'(dut_addr), 4); chk("hm_nohalt", int'(dut_halt), 0);

    // Async reset in the middle of a memory wait.
    cyc(mw(1, 0, 0, 0), 0, 0, 0, 0); chk("pre_rst_stall", int'(dut_stall), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_addr", int'(dut_addr), 0);
    chk("arst_stall", int'(dut_stall), 0);
    chk("arst_timeout", int'(dut_to), 0);
    chk("arst_halted", int'(dut_halt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(mw(0, 0, 0, 0), 0, 0, 1, 0); chk("post_rst", int'(dut_addr), 1);

    // Randomized traffic.
    slow = 0;
    hl   = 0;
    for (int n = 0; n < 3000; n++) begin
      w      = 41'({$urandom, $urandom});
      w[19]  = ($urandom % 4) == 0;
      w[18]  = ($urandom % 5) == 0;
      ir     = $urandom;
      if (slow > 0) begin
        rdy = 0; slow--;
      end else begin
        rdy = ($urandom % 3) != 0;
        if (($urandom % 40) == 0) slow = 3 + int'($urandom % 4);
      end
      if (hl > 0) begin
        hlt = 1; hl--;
      end else begin
        hlt = 0;
        if (($urandom % 20) == 0) hl = 1 + int'($urandom % 4);
      end
      cyc(w, ir, 4'($urandom), rdy, hlt);
      if ((n % 700) == 699) async_reset();
    end

    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
